program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Stream-in and RAM-write bus bundle for the program loader.
// The slave side is the loader; the master side feeds bytes and receives writes.
interface program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: count, N program bytes, checksum.
// Writes the image into RAM, zero-fills the rest, holds the CPU meanwhile.
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    program_loader_if.slave       bus,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

    logic [2:0]        state;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] sum;
    logic              xfer;
    logic [ADDR_W:0]   ptr_nxt;

    assign xfer    = bus.in_valid & bus.in_ready;
    assign ptr_nxt = ptr + 1'b1;

    // Session FSM; all outputs are registered and change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            sum           <= '0;
            bus.in_ready  <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            bus.ram_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_COUNT;
                        ptr          <= '0;
                        sum          <= '0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        err_code     <= 2'b00;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        if (bus.in_data == '0 || bus.in_data > DEPTH_B) begin
                            state        <= S_ERR;
                            err          <= 1'b1;
                            err_code     <= 2'b01;
                            busy         <= 1'b0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state <= S_DATA;
                            cnt   <= bus.in_data[ADDR_W:0];
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        bus.ram_we    <= 1'b1;
                        bus.ram_addr  <= ptr[ADDR_W-1:0];
                        bus.ram_wdata <= bus.in_data;
                        sum           <= sum + bus.in_data;
                        ptr           <= ptr_nxt;
                        if (ptr_nxt == cnt) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data != sum) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            busy     <= 1'b0;
                        end else begin
                            // A full image reaches FILL with ptr at DEPTH and
                            // leaves on the next edge without writing.
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (ptr == DEPTH_P) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        bus.ram_we    <= 1'b1;
                        bus.ram_addr  <= ptr[ADDR_W-1:0];
                        bus.ram_wdata <= '0;
                        ptr           <= ptr_nxt;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Each task drives one scenario and checks its own results.
module tb_program_loader;
    logic       clk;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int total;
    int bad;
    int cyc;

    logic [3:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    program_loader_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

    program_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (ifc.slave),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM-side observer: logs every committed write with its cycle stamp.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.ram_we === 1'b1) begin
            wa.push_back(ifc.ram_addr);
            wd.push_back(ifc.ram_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int n;
        ifc.in_valid = 1'b0;
        repeat (gaps) tick();
        ifc.in_valid = 1'b1;
        ifc.in_data = b;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", ifc.in_ready);
        end else begin
            tick();
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL wait_end timeout: done=%b err=%b", done, err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ifc.in_ready, ifc.ram_we, cpu_hold, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b required 000000",
                     ifc.in_ready, ifc.ram_we, cpu_hold, busy, done, err);
        end
        total++;
        if (ifc.ram_addr !== 4'h0 || ifc.ram_wdata !== 8'h00 || err_code !== 2'b00) begin
            bad++;
            $display("FAIL reset_bus: addr=%h wdata=%h code=%b required 0 00 00",
                     ifc.ram_addr, ifc.ram_wdata, err_code);
        end
        ifc.in_valid = 1'b1;
        ifc.in_data = 8'h55;
        repeat (4) tick();
        ifc.in_valid = 1'b0;
        total++;
        if (wa.size() != 0 || ifc.ram_we !== 1'b0 || ifc.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_xfer: writes=%0d we=%b ready=%b required 0 0 0",
                     wa.size(), ifc.ram_we, ifc.in_ready);
        end
    endtask

    task automatic test_load5();
        logic [7:0] img[16];
        img = '{8'h79, 8'h30, 8'h7A, 8'h80, 8'hF0, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        pulse_start();
        total++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || ifc.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_flags: busy=%b hold=%b ready=%b required 1 1 1",
                     busy, cpu_hold, ifc.in_ready);
        end
        send_byte(8'h05, 0);
        for (int i = 0; i < 5; i++) send_byte(img[i], 0);
        send_byte(8'h93, 0);
        total++;
        if (ifc.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_check: got %b required 0", ifc.in_ready);
        end
        wait_end();
        total++;
        if (wa.size() != 16) begin
            bad++;
            $display("FAIL load5_count: writes=%0d required 16", wa.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (wa[i] !== 4'(i) || wd[i] !== img[i]) begin
                    bad++;
                    $display("FAIL load5_word%0d: addr=%h data=%h required %h %h",
                             i, wa[i], wd[i], 4'(i), img[i]);
                end
            end
            total++;
            if (wc[4] - wc[0] != 4 || wc[5] - wc[4] != 2 || wc[15] - wc[5] != 10) begin
                bad++;
                $display("FAIL load5_timing: stamps %0d %0d %0d %0d required gaps 4 2 10",
                         wc[0], wc[4], wc[5], wc[15]);
            end
        end
        total++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL load5_end: done=%b hold=%b busy=%b err=%b required 1 0 0 0",
                     done, cpu_hold, busy, err);
        end
    endtask

    task automatic test_full();
        int last;
        do_reset();
        pulse_start();
        send_byte(8'h10, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        send_byte(8'h78, 0);
        last = cyc;
        wait_end();
        total++;
        if (cyc - last != 1) begin
            bad++;
            $display("FAIL full_done_latency: cycles=%0d required 1", cyc - last);
        end
        total++;
        if (wa.size() != 16) begin
            bad++;
            $display("FAIL full_count: writes=%0d required 16", wa.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (wa[i] !== 4'(i) || wd[i] !== 8'(i)) begin
                    bad++;
                    $display("FAIL full_word%0d: addr=%h data=%h required %h %h",
                             i, wa[i], wd[i], 4'(i), 8'(i));
                end
            end
        end
        total++;
        if (done !== 1'b1 || ifc.ram_we !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL full_end: done=%b we=%b hold=%b required 1 0 0",
                     done, ifc.ram_we, cpu_hold);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h0B, 0);
        send_byte(8'h00, 0);
        wait_end();
        repeat (20) tick();
        total++;
        if (wa.size() != 2 || wa[0] !== 4'h0 || wd[0] !== 8'h01 ||
            wa[1] !== 4'h1 || wd[1] !== 8'h0B) begin
            bad++;
            $display("FAIL badsum_writes: count=%0d required 2 at addr 0,1", wa.size());
        end
        total++;
        if (err !== 1'b1 || err_code !== 2'b10 || cpu_hold !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL badsum_flags: err=%b code=%b hold=%b busy=%b done=%b required 1 10 1 0 0",
                     err, err_code, cpu_hold, busy, done);
        end
        pulse_start();
        total++;
        if (err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL badsum_restart: err=%b code=%b busy=%b required 0 00 1",
                     err, err_code, busy);
        end
        pulse_start();
        total++;
        if (busy !== 1'b1 || ifc.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_while_busy: busy=%b ready=%b required 1 1",
                     busy, ifc.in_ready);
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] cnts[2];
        cnts = '{8'h00, 8'h11};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            send_byte(cnts[k], 0);
            ifc.in_valid = 1'b1;
            ifc.in_data = 8'hAA;
            repeat (3) tick();
            ifc.in_valid = 1'b0;
            total++;
            if (err !== 1'b1 || err_code !== 2'b01 || ifc.in_ready !== 1'b0 ||
                cpu_hold !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL badcount_%h: err=%b code=%b ready=%b hold=%b busy=%b required 1 01 0 1 0",
                         cnts[k], err, err_code, ifc.in_ready, cpu_hold, busy);
            end
            total++;
            if (wa.size() != 0) begin
                bad++;
                $display("FAIL badcount_%h_we: writes=%0d required 0", cnts[k], wa.size());
            end
        end
    endtask

    task automatic test_handshake();
        logic [7:0] img[4];
        img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_reset();
        pulse_start();
        send_byte(8'h04, $urandom_range(0, 2));
        for (int i = 0; i < 4; i++) send_byte(img[i], $urandom_range(0, 3));
        send_byte(8'hEA, $urandom_range(0, 2));
        wait_end();
        total++;
        if (wa.size() != 16 || done !== 1'b1) begin
            bad++;
            $display("FAIL hs_count: writes=%0d done=%b required 16 1", wa.size(), done);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wa[i] !== 4'(i) || wd[i] !== img[i]) begin
                    bad++;
                    $display("FAIL hs_word%0d: addr=%h data=%h required %h %h",
                             i, wa[i], wd[i], 4'(i), img[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        send_byte(8'h08, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({ifc.in_ready, ifc.ram_we, cpu_hold, busy, done, err} !== 6'b0 ||
            ifc.ram_addr !== 4'h0 || ifc.ram_wdata !== 8'h00 || err_code !== 2'b00) begin
            bad++;
            $display("FAIL midreset: flags=%b%b%b%b%b%b addr=%h wdata=%h required all zero",
                     ifc.in_ready, ifc.ram_we, cpu_hold, busy, done, err,
                     ifc.ram_addr, ifc.ram_wdata);
        end
        total++;
        if (wa.size() != 3) begin
            bad++;
            $display("FAIL midreset_writes: count=%0d required 3", wa.size());
        end
        ifc.in_valid = 1'b1;
        ifc.in_data = 8'h44;
        repeat (3) tick();
        ifc.in_valid = 1'b0;
        total++;
        if (ifc.in_ready !== 1'b0 || busy !== 1'b0 || wa.size() != 3) begin
            bad++;
            $display("FAIL midreset_idle: ready=%b busy=%b writes=%0d required 0 0 3",
                     ifc.in_ready, busy, wa.size());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        reset = 1'b1;
        start = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = 8'h00;
        test_reset();
        test_load5();
        test_full();
        test_bad_checksum();
        test_bad_count();
        test_handshake();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
